// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   Registered N-channel stream multiplexer. Selects one producer stream per
//   cycle and drives a single consumer through one output register stage.
//   Mode 0 picks the channel given by 'sel'. Mode 1 arbitrates round-robin
//   and keeps a multi-beat packet on its channel until its last beat.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data           N_CH*WIDTH flattened data, channel i at [i*WIDTH +: WIDTH]
//   in_valid/in_last  per-channel valid and end-of-packet (qualified by valid)
//   in_ready          per-channel ready (combinational)
//   mode              0 = fixed select, 1 = round-robin with packet lock
//   sel               channel select, used in mode 0 only
//   out_data/out_last registered beat
//   out_ch            channel index that supplied the current beat
//   out_valid         output beat valid
//   out_ready         consumer ready
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. A producer holding valid=1 must keep its data and
// last stable until accepted; out_* stay stable while out_valid=1 and
// out_ready=0.
module stream_mux_rr #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic             load;
    logic             cand_ok;
    logic [SEL_W-1:0] cand;
    logic             cand_valid;
    logic             xfer;
    logic             rr_ok;
    logic [SEL_W-1:0] rr_ch;
    logic [SEL_W-1:0] idx;

    logic             locked;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] ptr;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Output register can take a new beat when empty or being drained.
    assign load = !out_valid || out_ready;

    // Round-robin search: first valid channel above ptr, wrapping at N_CH-1.
    always_comb begin
        rr_ok = 1'b0;
        rr_ch = '0;
        idx   = ptr;
        for (int k = 0; k < N_CH; k++) begin
            idx = (idx == SEL_W'(N_CH - 1)) ? '0 : idx + 1'b1;
            if (!rr_ok && in_valid[idx]) begin
                rr_ok = 1'b1;
                rr_ch = idx;
            end
        end
    end

    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        if (!mode) begin
            // Extra bit so the compare also works when N_CH == 2**SEL_W.
            cand    = sel;
            cand_ok = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
        end else if (locked) begin
            cand    = lock_ch;
            cand_ok = 1'b1;
        end else begin
            cand    = rr_ch;
            cand_ok = rr_ok;
        end
    end

    assign cand_valid = cand_ok && in_valid[cand];
    assign xfer       = load && cand_valid;

    // Ready is forced low during reset; in mode 0 it does not wait for valid.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = rst_n && load && cand_ok && (cand == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
            ptr       <= SEL_W'(N_CH - 1);
        end else begin
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= ch_data[cand];
                    out_last <= in_last[cand];
                    out_ch   <= cand;
                end
            end
            // Leaving round-robin mode abandons any packet lock.
            if (!mode) begin
                locked <= 1'b0;
            end else if (xfer) begin
                ptr <= cand;
                if (in_last[cand]) begin
                    locked <= 1'b0;
                end else begin
                    locked  <= 1'b1;
                    lock_ch <= cand;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;

  // 8-channel instance
  logic [63:0] in_data8;
  logic [7:0]  in_valid8;
  logic [7:0]  in_last8;
  logic [7:0]  in_ready8;
  logic        mode8;
  logic [2:0]  sel8;
  logic [7:0]  out_data8;
  logic        out_last8;
  logic [2:0]  out_ch8;
  logic        out_valid8;
  logic        out_ready8;

  // 5-channel instance (out-of-range select)
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_last5;
  logic [4:0]  in_ready5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic        out_last5;
  logic [2:0]  out_ch5;
  logic        out_valid5;
  logic        out_ready5;

  int checks = 0;
  int errors = 0;

  // expected beats as {ch, last, data}
  logic [11:0] exp_q[$];

  stream_mux_rr #(.N_CH(8), .WIDTH(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data8), .in_valid(in_valid8), .in_last(in_last8),
    .in_ready(in_ready8), .mode(mode8), .sel(sel8),
    .out_data(out_data8), .out_last(out_last8), .out_ch(out_ch8),
    .out_valid(out_valid8), .out_ready(out_ready8)
  );

  stream_mux_rr #(.N_CH(5), .WIDTH(8), .SEL_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data5), .in_valid(in_valid5), .in_last(in_last5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5),
    .out_data(out_data5), .out_last(out_last5), .out_ch(out_ch5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = base + 8'(i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare the presented beat against the head of exp_q
  task automatic check_beat(input string tag);
    logic [11:0] exp;
    exp = 12'hFFF;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, "_valid"}, 32'(out_valid8), 32'd1);
    check(tag, 32'({out_ch8, out_last8, out_data8}), 32'(exp));
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data8   = '0;
    set_data8(8'h10);
    in_valid8  = 8'hFF;
    in_last8   = 8'h00;
    mode8      = 1'b0;
    sel8       = 3'd0;
    out_ready8 = 1'b1;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h50 + 8'(i);
    in_valid5  = 5'h1F;
    in_last5   = 5'h1F;
    mode5      = 1'b0;
    sel5       = 3'd4;
    out_ready5 = 1'b1;

    // reset state
    #12;
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_out_data", 32'(out_data8), 32'h00);
    check("rst_out_ch", 32'(out_ch8), 32'd0);
    check("rst_out_last", 32'(out_last8), 32'd0);
    check("rst_in_ready", 32'(in_ready8), 32'h00);
    tick();
    rst_n = 1'b1;
    #1;

    // 1. fixed-mode sweep
    check("fix_ready_0", 32'(in_ready8), 32'h01);
    for (int s = 0; s < 8; s++) begin
      tick();
      check("fix_valid", 32'(out_valid8), 32'd1);
      check("fix_data", 32'(out_data8), 32'h10 + 32'(s));
      check("fix_ch", 32'(out_ch8), 32'(s));
      if (s < 7) begin
        sel8 = 3'(s + 1);
        #1;
        check("fix_ready", 32'(in_ready8), 32'(8'h01 << (s + 1)));
      end
    end

    // 2. round-robin fairness from reset
    rst_n     = 1'b0;
    mode8     = 1'b1;
    in_last8  = 8'hFF;
    in_valid8 = 8'hFF;
    #1;
    rst_n = 1'b1;
    #1;
    check("rr_ready_first", 32'(in_ready8), 32'h01);
    for (int j = 0; j < 10; j++) begin
      tick();
      check("rr_valid", 32'(out_valid8), 32'd1);
      check("rr_ch", 32'(out_ch8), 32'(j % 8));
      check("rr_data", 32'(out_data8), 32'h10 + 32'(j % 8));
      check("rr_ready", 32'(in_ready8), 32'(8'h01 << ((j + 1) % 8)));
    end

    // drain (pointer now at ch1)
    in_valid8 = 8'h00;
    tick();
    check("drain_valid", 32'(out_valid8), 32'd0);

    // 3. packet lock: ch2 A0..A2 vs ch5 B0
    in_data8[2*8 +: 8] = 8'hA0;
    in_data8[5*8 +: 8] = 8'hB0;
    in_valid8 = 8'b0010_0100;
    in_last8  = 8'b0010_0000;
    exp_q.push_back({3'd2, 1'b0, 8'hA0});
    exp_q.push_back({3'd2, 1'b0, 8'hA1});
    exp_q.push_back({3'd2, 1'b1, 8'hA2});
    exp_q.push_back({3'd5, 1'b1, 8'hB0});
    #1;
    check("lock_ready_a0", 32'(in_ready8), 32'h04);
    tick();
    check_beat("lock_a0");
    in_data8[2*8 +: 8] = 8'hA1;
    #1;
    check("lock_ready_a1", 32'(in_ready8), 32'h04);
    tick();
    check_beat("lock_a1");
    in_data8[2*8 +: 8] = 8'hA2;
    in_last8[2] = 1'b1;
    #1;
    check("lock_ready_a2", 32'(in_ready8), 32'h04);
    tick();
    check_beat("lock_a2");
    in_valid8[2] = 1'b0;
    #1;
    check("lock_ready_b0", 32'(in_ready8), 32'h20);
    tick();
    check_beat("lock_b0");
    in_valid8 = 8'h00;
    tick();
    check("lock_idle", 32'(out_valid8), 32'd0);
    check("lock_q_empty", 32'(exp_q.size()), 32'd0);

    // 4. backpressure on a locked ch6 packet
    in_data8[6*8 +: 8] = 8'hC0;
    in_last8  = 8'h00;
    in_valid8 = 8'h40;
    #1;
    check("bp_ready_c0", 32'(in_ready8), 32'h40);
    exp_q.push_back({3'd6, 1'b0, 8'hC0});
    tick();
    check_beat("bp_c0");
    out_ready8 = 1'b0;
    in_data8[6*8 +: 8] = 8'hC1;
    in_last8[6] = 1'b1;
    #1;
    check("bp_ready_stall", 32'(in_ready8), 32'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid8), 32'd1);
      check("bp_hold_beat", 32'({out_ch8, out_last8, out_data8}), 32'({3'd6, 1'b0, 8'hC0}));
      check("bp_hold_ready", 32'(in_ready8), 32'h00);
    end
    out_ready8 = 1'b1;
    #1;
    check("bp_ready_release", 32'(in_ready8), 32'h40);
    exp_q.push_back({3'd6, 1'b1, 8'hC1});
    tick();
    check_beat("bp_c1");
    in_valid8 = 8'h00;
    tick();
    check("bp_no_dup", 32'(out_valid8), 32'd0);

    // 5. out-of-range select on the 5-channel instance
    check("oor_sel4_valid", 32'(out_valid5), 32'd1);
    check("oor_sel4_ch", 32'(out_ch5), 32'd4);
    check("oor_sel4_data", 32'(out_data5), 32'h54);
    check("oor_sel4_ready", 32'(in_ready5), 32'h10);
    sel5 = 3'd6;
    #1;
    check("oor_sel6_ready", 32'(in_ready5), 32'h00);
    tick();
    check("oor_sel6_valid", 32'(out_valid5), 32'd0);
    tick();
    check("oor_sel6_valid2", 32'(out_valid5), 32'd0);
    check("oor_sel6_ready2", 32'(in_ready5), 32'h00);
    sel5 = 3'd5;
    #1;
    check("oor_sel5_ready", 32'(in_ready5), 32'h00);

    // 6. reset mid-packet (pointer at ch6)
    in_data8[3*8 +: 8] = 8'hD0;
    in_last8  = 8'h00;
    in_valid8 = 8'h08;
    #1;
    check("mid_ready_d0", 32'(in_ready8), 32'h08);
    tick();
    check("mid_beat_d0", 32'({out_valid8, out_ch8, out_last8, out_data8}), 32'({1'b1, 3'd3, 1'b0, 8'hD0}));
    set_data8(8'h10);
    in_valid8 = 8'hFF;
    in_last8  = 8'hFF;
    #1;
    check("mid_locked_ready", 32'(in_ready8), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid8), 32'd0);
    check("mid_rst_ready", 32'(in_ready8), 32'h00);
    check("mid_rst_data", 32'(out_data8), 32'h00);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(in_ready8), 32'h01);
    tick();
    check("mid_rel_beat0", 32'({out_valid8, out_ch8, out_last8, out_data8}), 32'({1'b1, 3'd0, 1'b1, 8'h10}));
    check("mid_rel_ready1", 32'(in_ready8), 32'h02);
    tick();
    check("mid_rel_beat1", 32'({out_valid8, out_ch8, out_last8, out_data8}), 32'({1'b1, 3'd1, 1'b1, 8'h11}));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-channel stream multiplexer with valid/ready handshakes. It is the next generation of the team's combinational 8-to-1 multiplexer. It supports a fixed-select mode that preserves the old select-line behaviour, and a round-robin arbitration mode with packet locking. It sits between multiple producer streams and a single consumer, and adds exactly one register stage on the output.

## Interface
- `N_CH`, default 8: number of input channels, minimum 2.
- `WIDTH`, default 8: data width per channel.
- `SEL_W`, default 3: select/channel-index width; must equal clog2(N_CH).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_data` input N_CH*WIDTH: flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` input N_CH: per-channel valid.
- `in_last` input N_CH: per-channel end-of-packet flag, qualified by in_valid.
- `in_ready` output N_CH: per-channel ready, combinational.
- `mode` input 1: 0 = fixed select, 1 = round-robin.
- `sel` input SEL_W: channel select, used only in mode 0.
- `out_data` output WIDTH: registered data.
- `out_last` output 1: registered end-of-packet flag.
- `out_ch` output SEL_W: index of the channel that supplied the current output beat.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: consumer ready.

## Operation
- **Output register load condition:** load = !out_valid || out_ready.
- **Candidate channel `cand`:**
  - Mode 0: cand = sel. If sel >= N_CH, there is no candidate.
  - Mode 1, locked: cand = lock_ch.
  - Mode 1, unlocked: cand is the first channel with in_valid=1, searching upward from (ptr+1) mod N_CH and wrapping. If no channel is valid, there is no candidate.
- **Ready:** in_ready[i] = load && candidate exists && (i == cand). All other in_ready bits are 0. In mode 0, in_ready[sel] does not depend on in_valid.
- **Transfer:** a transfer occurs when in_valid[cand] && in_ready[cand]. On a transfer, the block captures out_data, out_last and out_ch from cand and sets out_valid=1.
- **No input transfer:** if load=1 and no transfer occurs, out_valid←0 and data registers hold their value.
- **Output hold:** when out_valid=1 and out_ready=0, out_data, out_last and out_ch are held stable.
- **Round-robin pointer `ptr`:** in mode 1, every transfer sets ptr←cand. The pointer is not updated in mode 0.
- **Lock (mode 1 only):**
  - A transfer with in_last=0 sets locked←1 and lock_ch←cand.
  - A transfer with in_last=1 sets locked←0.
  - A single-beat packet (in_last=1 on its first beat) never locks.
- **Mode change:** whenever mode=0 at a clock edge, locked←0. Mode is evaluated combinationally each cycle. Switching mode between beats is legal; a packet interrupted by a switch to mode 0 loses its lock.
- **Reset values (while rst_n=0, applied asynchronously):**
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - locked=0, lock_ch=0, ptr=N_CH-1, so channel 0 is served first after reset.
  - in_ready is forced to all-zero.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is presented on out_* from just after edge k, until the edge at which out_ready=1.
- Throughput is 1 beat per cycle when out_ready is held at 1; there are no bubbles between channels or packets.
- The combinational paths in_valid→in_ready and out_ready→in_ready are expected and permitted. There is no combinational path from in_* to out_*.
- **Asynchronous reset assertion:** outputs clear immediately, without waiting for a clock edge. A packet in progress is dropped and the lock is cleared.
- **Reset release:** release is synchronised externally. The first transfer can occur at the first rising edge after rst_n goes high.
- **Simultaneous events:** a transfer and out_ready=1 in the same cycle replace the output beat; no data is lost or duplicated.

## Test plan
1. **Fixed-mode sweep** (N_CH=8, WIDTH=8, mode=0): all channels valid with data 8'h10+i, out_ready=1, sel stepped 0→7 once per cycle. Required: out_data 8'h10..8'h17 each one cycle after its sel value, out_ch equal to that sel, and only in_ready[sel] high.
2. **Round-robin fairness** (mode=1): all channels valid with single-beat packets (last=1), out_ready=1, starting from reset. Required: out_ch sequence 0,1,2,…,7,0,1 on consecutive cycles with out_valid continuously 1.
3. **Packet lock:** ch2 sends 3 beats A0, A1, A2 (last on A2) while ch5 is valid throughout with B0 (last=1). Required: output sequence A0, A1, A2, B0, and in_ready[5]=0 until A2 has been transferred.
4. **Backpressure:** with out_valid=1, hold out_ready=0 for 3 cycles. Required: out_data, out_ch and out_last stable and all in_ready=0 during the stall; after release, the next beats follow with no loss or duplication.
5. **Out-of-range select** (N_CH=5, SEL_W=3, mode=0, sel=6, all channels valid): in_ready stays 5'b00000 and out_valid stays 0.
6. **Reset mid-packet:** drive rst_n low between clock edges after ch3 has sent a non-last beat. Required: out_valid=0 and in_ready=0 immediately. After release with all channels valid in mode 1, channel 0 is served first and ch3 is not locked.
